piso_shifter: RTL

Parameterised parallel-in/serial-out shifter with a valid/ready handshake on both sides. It accepts a DATA_W-bit word and emits it as a stream of LANES-bit beats, MSB-first or LSB-first per word, with a programmable beat count and downstream backpressure. It sits between register-mapped or bus-side producers and serial links such as SPI-style, bit-bang or multi-lane serial transmit paths.

---
 rtl/piso_shifter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shifter with valid/ready on both sides, MSB- or LSB-first per word.
// Define PISO_PREFETCH_EN to add a one-word pending buffer for gap-free back-to-back words.
module piso_shifter #(
    parameter int DATA_W = 32,
    parameter int LANES  = 1,
    localparam int BEATS = DATA_W / LANES,
    localparam int CNT_W = $clog2(BEATS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_lsb_first,
    input  logic [CNT_W-1:0]  i_len,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [LANES-1:0]  o_data,
    output logic              o_last,
    output logic              o_busy
);

    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   sreg_q, sreg_d;
    logic                lsb_q, lsb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic [LANES-1:0]    data_q, data_d;
    logic                accept;
    logic                beatDone;

`ifdef PISO_PREFETCH_EN
    logic                pendValid_q, pendValid_d;
    logic [DATA_W-1:0]   pendData_q, pendData_d;
    logic                pendLsb_q, pendLsb_d;
    logic [CNT_W-1:0]    pendLen_q, pendLen_d;
    logic                takeDirect;
`endif

    // A zero or oversized length means "the whole word".
    function automatic logic [CNT_W-1:0] effLen(input logic [CNT_W-1:0] len);
        return ((len == '0) || (len > BEATS_C)) ? BEATS_C : len;
    endfunction

    function automatic logic [LANES-1:0] beatOf(input logic [DATA_W-1:0] word, input logic lsb);
        return lsb ? word[LANES-1:0] : word[DATA_W-1 -: LANES];
    endfunction

    function automatic logic [DATA_W-1:0] shiftOut(input logic [DATA_W-1:0] word, input logic lsb);
        return lsb ? (word >> LANES) : (word << LANES);
    endfunction

    assign accept   = i_valid && ready_q;
    assign beatDone = valid_q && i_ready;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        lsb_d   = lsb_q;
        cnt_d   = cnt_q;
`ifdef PISO_PREFETCH_EN
        pendValid_d = pendValid_q;
        pendData_d  = pendData_q;
        pendLsb_d   = pendLsb_q;
        pendLen_d   = pendLen_q;
        takeDirect  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    sreg_d  = i_data;
                    lsb_d   = i_lsb_first;
                    cnt_d   = effLen(i_len);
`ifdef PISO_PREFETCH_EN
                    takeDirect = 1'b1;
`endif
                end
            end
            SHIFT: begin
                if (beatDone) begin
                    if (cnt_q == ONE_C) begin
`ifdef PISO_PREFETCH_EN
                        // Chain straight into the next word so the output never bubbles.
                        if (pendValid_q) begin
                            sreg_d      = pendData_q;
                            lsb_d       = pendLsb_q;
                            cnt_d       = pendLen_q;
                            pendValid_d = 1'b0;
                        end else if (accept) begin
                            sreg_d     = i_data;
                            lsb_d      = i_lsb_first;
                            cnt_d      = effLen(i_len);
                            takeDirect = 1'b1;
                        end else begin
                            state_d = IDLE;
                            sreg_d  = '0;
                            cnt_d   = '0;
                        end
`else
                        state_d = IDLE;
                        sreg_d  = '0;
                        cnt_d   = '0;
`endif
                    end else begin
                        sreg_d = shiftOut(sreg_q, lsb_q);
                        cnt_d  = cnt_q - ONE_C;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef PISO_PREFETCH_EN
        if (accept && !takeDirect) begin
            pendValid_d = 1'b1;
            pendData_d  = i_data;
            pendLsb_d   = i_lsb_first;
            pendLen_d   = effLen(i_len);
        end
        ready_d = !pendValid_d;
`else
        ready_d = (state_d == IDLE);
`endif

        // Outputs are computed from next state so they appear registered with no extra latency.
        valid_d = (state_d == SHIFT);
        busy_d  = valid_d;
        last_d  = valid_d && (cnt_d == ONE_C);
        data_d  = valid_d ? beatOf(sreg_d, lsb_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            lsb_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
`ifdef PISO_PREFETCH_EN
            pendValid_q <= 1'b0;
            pendData_q  <= '0;
            pendLsb_q   <= 1'b0;
            pendLen_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            lsb_q   <= lsb_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            data_q  <= data_d;
`ifdef PISO_PREFETCH_EN
            pendValid_q <= pendValid_d;
            pendData_q  <= pendData_d;
            pendLsb_q   <= pendLsb_d;
            pendLen_q   <= pendLen_d;
`endif
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_last  = last_q;
    assign o_busy  = busy_q;
    assign o_data  = data_q;

endmodule
